// File: rtl/decimal_entry.sv
// Keypad-style decimal entry: BCD digits are shifted in one at a time from SW on
// debounced enterBtn presses. A debounced commitBtn press converts them to binary
// sequentially, one multiply-by-10 accumulate step per clock, most significant digit first.
module decimal_entry #(
    parameter int unsigned NUM_DIGITS      = 9,
    parameter int unsigned BIN_W           = 30,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [3:0]              SW,
    input  logic                    enterBtn,
    input  logic                    commitBtn,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [3:0]              count,
    output logic [BIN_W-1:0]        value,
    output logic                    valid,
    output logic                    busy,
    output logic                    error
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DigW = 4 * NUM_DIGITS;
    localparam logic [CntW-1:0] DbMax   = CntW'(DEBOUNCE_CYCLES);
    localparam logic [3:0]      MaxCnt  = 4'(NUM_DIGITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    typedef enum logic {StEntry, StConvert} state_e;

    // Button conditioning, bit 0 = enter, bit 1 = commit (both active low)
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_prev_q;
    logic [CntW-1:0] db_cnt_q [2];
    logic            enter_ev, commit_ev;

    assign btn_raw = {commitBtn, enterBtn};

    // Synchronize, debounce and remember the previous stable level for edge detection
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            stable_q      <= '1;
            stable_prev_q <= '1;
            db_cnt_q[0]   <= '0;
            db_cnt_q[1]   <= '0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 2; i++) begin
                // sync1 != sync2 means the synchronized level changes at this edge
                if (sync1_q[i] != sync2_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbMax) begin
                    stable_q[i] <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press (1->0) of the stable level gives a one-cycle event
    assign enter_ev  = stable_prev_q[0] & ~stable_q[0];
    assign commit_ev = stable_prev_q[1] & ~stable_q[1];

    // Entry / conversion state
    state_e           state_q, state_d;
    logic [DigW-1:0]  digits_q, digits_d;
    logic [3:0]       count_q, count_d;
    logic [BIN_W-1:0] value_q, value_d;
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic [3:0]       cur_digit;

    assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

    // State register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StEntry;
            digits_q <= '0;
            count_q  <= '0;
            value_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            value_q  <= value_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    // Next-state: digit entry, commit handling and the convert loop
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        value_d  = value_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        error_d  = error_q;

        unique case (state_q)
            StEntry: begin
                // Commit takes priority; a simultaneous enter is silently dropped
                if (commit_ev) begin
                    if (count_q == 4'd0) begin
                        error_d = 1'b1;
                    end else begin
                        acc_d   = '0;
                        idx_d   = LastIdx;
                        state_d = StConvert;
                    end
                end else if (enter_ev) begin
                    if (SW > 4'd9 || count_q == MaxCnt) begin
                        error_d = 1'b1;
                    end else begin
                        digits_d = {digits_q[DigW-5:0], SW};
                        count_d  = count_q + 4'd1;
                        error_d  = 1'b0;
                        valid_d  = 1'b0;
                    end
                end
            end
            StConvert: begin
                // acc * 10 + digit; unused leading digits are zero
                acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(cur_digit);
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    value_d  = acc_d;
                    valid_d  = 1'b1;
                    digits_d = '0;
                    count_d  = '0;
                    error_d  = 1'b0;
                    state_d  = StEntry;
                end
            end
            default: state_d = StEntry;
        endcase
    end

    assign digits_o = digits_q;
    assign count    = count_q;
    assign value    = value_q;
    assign valid    = valid_q;
    assign busy     = (state_q == StConvert);
    assign error    = error_q;

endmodule
